fdct_row_serial: RTL
====================

// Module: fdct_row_serial
// PURPOSE
//  Encoder-side 8-point 1-D forward DCT for one row/column of an 8x8 JPEG block.
//  - Accepts 8 pixels serially over a valid/ready handshake.
//  - Level-shifts each pixel and computes all 8 coefficients.
//  - Streams coefficients out serially (u=0..7).
//  - Sits between the block raster buffer and the quantiser; two passes (row, column) form the 2-D FDCT.
// PARAMETERS
//  IN_W        8   pixel width (unsigned)
//  OUT_W       12  coefficient width (signed, two's complement)
//  LEVEL_SHIFT 1   1: s = pix - 128; 0: pix taken as signed IN_W input (second pass)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      in_pix valid
//  in_ready   out  1      block can accept a sample
//  in_pix     in   IN_W   sample x, x = 0..7 in arrival order
//  out_valid  out  1      out_coef valid
//  out_ready  in   1      downstream accepts coefficient
//  out_coef   out  OUT_W  coefficient F(u)
//  out_idx    out  3      u of current coefficient
//  out_last   out  1      high with u = 7
//  busy       out  1      high in any state but LOAD with cnt = 0
// BEHAVIOUR
//  Reset values:
//  - all outputs 0 except in_ready = 1.
//  - FSM = LOAD, sample counter cnt = 0, buffer contents don't-care.
//  FSM (2 states):
//  - LOAD:
//    - in_ready = 1.
//    - On in_valid & in_ready: buf[cnt] <= s, cnt++.
//    - When the 8th sample (cnt = 7) is accepted: go to EMIT, u <= 0.
//  - EMIT:
//    - in_ready = 0.
//    - out_valid is registered; first coefficient appears the cycle after the 8th sample is accepted (latency 1).
//    - On out_valid & out_ready: advance u. If u = 7 (out_last), return to LOAD with cnt = 0; in_ready = 1 that next cycle.
//    - No overlap of load and emit: throughput is 16 cycles/row at full handshake.
//  Handshake rules:
//  - While out_valid = 1 and out_ready = 0: out_coef, out_idx and out_last hold stable.
//  - out_valid never drops without a transfer.
//  - in_valid while in_ready = 0 is ignored (no capture).
//  Arithmetic:
//  - Level shift: s = in_pix - 128, signed IN_W+1 bits.
//  - Accumulator: acc(u) = sum over x of s[x] * M[u][x], signed 19 bits, no overflow possible.
//  - Matrix: M[0][x] = 45. For u > 0, M[u][x] = T((2x+1)*u mod 32), where T(k) = round(64*cos(k*pi/16)).
//    - T(0..8) = 64, 63, 59, 53, 45, 36, 24, 12, 0.
//    - Sign and mirror per cosine symmetry (T(16-k) = -T(k), T(32-k) = T(k)).
//  - Output: F(u) = (acc + 64) >>> 7, i.e. round half toward +inf, then sign-extended to OUT_W.
//    - Range is about +/-512, so no saturation is needed.
//  - Constant multiplies may use shift-add or multipliers; the result must be bit-exact to the formula above.
//  Boundary conditions:
//  - Reset mid-LOAD or mid-EMIT: partial row discarded, out_valid drops immediately (asynchronous), next row starts at x = 0.
//  - in_valid held continuously through EMIT: samples are not consumed until in_ready returns.
//  - out_ready tied high: 8 consecutive output cycles, then in_ready = 1 on the following cycle.
// TESTING
//  - All pixels 128 (s = 0) -> out_coef = 0 for u = 0..7, out_last only at u = 7.
//  - All pixels 255 -> F(0) = 357, F(1..7) = 0.
//  - All pixels 0 -> F(0) = -360, F(1..7) = 0 (checks negative rounding).
//  - Impulse: x0 = 228, others 128 -> F(0) = 35, F(1) = 49, F(7) = 9; full row checked against the reference model.
//  - out_ready low 5 cycles at u = 3 -> out_coef, out_idx = 3 stable; in_ready stays 0; no sample consumed.
//  - rst pulse after 5 samples, then a new row of 255 -> F(0) = 357 (no stale samples used).

Source files
------------

// File: rtl/fdct_row_serial.sv
// rtl/fdct_row_serial.sv - serial 8-point 1-D forward DCT row engine (load 8, emit 8)
module fdct_row_serial #(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 12,
  parameter bit LEVEL_SHIFT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_coef,
  output logic [2:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam int S_W   = IN_W + 1;
  localparam int ACC_W = 19;

  typedef enum logic {ST_LOAD, ST_EMIT} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         u_q, u_d;
  logic               buf_we;
  logic [S_W-1:0]     buf_q [8];
  logic [S_W-1:0]     s_in;
  logic [S_W-1:0]     pix_ext;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   rnd;
  logic [ACC_W-1:0]   prod;
  logic [7:0]         w;
  logic [6:0]         unused_rnd_lsb;

  // Cosine table T(k) = round(64*cos(k*pi/16)), folded onto the first quadrant.
  function automatic logic [7:0] cos_t(input logic [4:0] k);
    logic [4:0] m;
    logic       neg;
    logic [7:0] mag;
    if (k <= 5'd8) begin
      m = k;            neg = 1'b0;
    end else if (k <= 5'd16) begin
      m = 5'd16 - k;    neg = 1'b1;
    end else if (k <= 5'd24) begin
      m = k - 5'd16;    neg = 1'b1;
    end else begin
      m = 5'd0 - k;     neg = 1'b0;
    end
    case (m)
      5'd0:    mag = 8'd64;
      5'd1:    mag = 8'd63;
      5'd2:    mag = 8'd59;
      5'd3:    mag = 8'd53;
      5'd4:    mag = 8'd45;
      5'd5:    mag = 8'd36;
      5'd6:    mag = 8'd24;
      5'd7:    mag = 8'd12;
      default: mag = 8'd0;
    endcase
    return neg ? (8'd0 - mag) : mag;
  endfunction

  // Level shift (first pass) or signed pass-through (second pass).
  always_comb begin
    pix_ext = {1'b0, in_pix};
    if (LEVEL_SHIFT) begin
      s_in = pix_ext - S_W'(1 << (IN_W - 1));
    end else begin
      s_in = {in_pix[IN_W-1], in_pix};
    end
  end

  // State, sample counter and coefficient index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= 3'd0;
      u_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
    end
  end

  // Sample buffer; contents after reset are irrelevant because cnt restarts at 0.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[cnt_q] <= s_in;
    end
  end

  // Next-state and handshake outputs: load eight samples, then emit eight coefficients.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    u_d       = u_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    buf_we    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_EMIT;
            u_d     = 3'd0;
            cnt_d   = 3'd0;
          end
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          u_d = u_q + 3'd1;
          if (u_q == 3'd7) begin
            state_d = ST_LOAD;
            u_d     = 3'd0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Dot product of the buffered row with basis u; stable while u and the buffer hold.
  always_comb begin
    acc  = '0;
    prod = '0;
    w    = '0;
    for (int x = 0; x < 8; x++) begin
      if (u_q == 3'd0) begin
        w = 8'd45;
      end else begin
        w = cos_t(5'((2 * x + 1) * int'(u_q)));
      end
      prod = {{(ACC_W-S_W){buf_q[x][S_W-1]}}, buf_q[x]} * {{(ACC_W-8){w[7]}}, w};
      acc  = acc + prod;
    end
    rnd = acc + ACC_W'(64);
  end

  assign unused_rnd_lsb = rnd[6:0];
  assign out_coef = out_valid ? OUT_W'($signed(rnd[ACC_W-1:7])) : '0;
  assign out_idx  = out_valid ? u_q : 3'd0;
  assign out_last = out_valid && (u_q == 3'd7);
  assign busy     = !((state_q == ST_LOAD) && (cnt_q == 3'd0));

endmodule
